// File: rtl/therm_pkg.sv
// Shared types and constants for the thermistor ADC sampling front end.
package therm_pkg;

    localparam int THERM_FRAME_BITS = 16;
    localparam int THERM_CODE_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_QUIET,
        ST_ACCUM
    } therm_state_e;

endpackage

// File: rtl/therm_spi_rx.sv
// SCLK generator and 16-bit frame receiver; keeps the 8 data bits that
// follow LEAD_BITS leading bits, MSB first.
module therm_spi_rx
    import therm_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int LEAD_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    sdo,
    output logic                    sclk,
    output logic                    done,
    output logic [THERM_CODE_W-1:0] sample
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(THERM_FRAME_BITS);

    logic             active;
    logic             phase;
    logic [DIV_W-1:0] half_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             sdo_q;
    logic             half_end;
    logic             capture;
    logic             keep;

    assign half_end = (half_cnt == DIV_W'(CLK_DIV - 1));
    // The first cycle of each high phase samples the registered SDO.
    assign capture  = active && phase && (half_cnt == '0);
    assign keep     = (int'(bit_cnt) >= LEAD_BITS) &&
                      (int'(bit_cnt) < LEAD_BITS + THERM_CODE_W);
    assign sclk     = active && phase;
    assign done     = active && phase && half_end &&
                      (bit_cnt == BIT_W'(THERM_FRAME_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            phase    <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            sdo_q    <= 1'b0;
            sample   <= '0;
        end else begin
            sdo_q <= sdo;
            if (start) begin
                active   <= 1'b1;
                phase    <= 1'b0;
                half_cnt <= '0;
                bit_cnt  <= '0;
            end else if (active) begin
                if (capture && keep) begin
                    sample <= {sample[THERM_CODE_W-2:0], sdo_q};
                end
                if (half_end) begin
                    half_cnt <= '0;
                    phase    <= ~phase;
                    if (phase) begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(THERM_FRAME_BITS - 1)) begin
                            active <= 1'b0;
                        end
                    end
                end else begin
                    half_cnt <= half_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/therm_adc_sampler.sv
// Periodic thermistor ADC reader: sequences SPI frames and box-car averages
// 2^AVG_LOG2 conversions into v_therm.
module therm_adc_sampler
    import therm_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int LEAD_BITS     = 3,
    parameter int AVG_LOG2      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_en,
    input  logic                    adc_sdo,
    output logic                    adc_cs_n,
    output logic                    adc_sclk,
    output logic [THERM_CODE_W-1:0] v_therm,
    output logic                    v_valid,
    output logic                    busy
);

    localparam int TMR_W = $clog2(SAMPLE_PERIOD);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int ACC_W = THERM_CODE_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    therm_state_e            state;
    therm_state_e            state_next;
    logic [TMR_W-1:0]        timer;
    logic                    tick;
    logic [DIV_W-1:0]        div_cnt;
    logic                    div_end;
    logic                    spi_start;
    logic                    spi_done;
    logic [THERM_CODE_W-1:0] sample;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_sum;
    logic [CNT_W-1:0]        cnt;

    therm_spi_rx #(
        .CLK_DIV   (CLK_DIV),
        .LEAD_BITS (LEAD_BITS)
    ) u_spi_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (spi_start),
        .sdo    (adc_sdo),
        .sclk   (adc_sclk),
        .done   (spi_done),
        .sample (sample)
    );

    assign tick     = (timer == TMR_W'(SAMPLE_PERIOD - 1));
    assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign adc_cs_n = !((state == ST_SETUP) || (state == ST_SHIFT));
    assign busy     = (state != ST_IDLE);
    assign acc_sum  = acc + ACC_W'(sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        spi_start  = 1'b0;
        case (state)
            ST_IDLE:  if (tick && start_en) state_next = ST_SETUP;
            ST_SETUP: begin
                if (div_end) begin
                    state_next = ST_SHIFT;
                    spi_start  = 1'b1;
                end
            end
            ST_SHIFT: if (spi_done) state_next = ST_QUIET;
            ST_QUIET: if (div_end) state_next = ST_ACCUM;
            ST_ACCUM: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Phase counter shared by the fixed-length SETUP and QUIET phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if ((state_next != state) ||
                     !((state == ST_SETUP) || (state == ST_QUIET))) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // v_valid is a bare one-cycle strobe with no ready: the consumer must
    // take v_therm in that cycle; v_therm then holds until the next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            v_therm <= '0;
            v_valid <= 1'b0;
        end else begin
            v_valid <= 1'b0;
            if (state == ST_ACCUM) begin
                if (cnt == CNT_LAST) begin
                    v_therm <= acc_sum[ACC_W-1 -: THERM_CODE_W];
                    v_valid <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end else if ((state == ST_IDLE) && !start_en) begin
                // Disabled and idle: restart the averaging window from scratch.
                acc <= '0;
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_therm_adc_sampler.sv
// Randomized self-checking bench: ADC frame model plus a windowed-average
// reference kept as a queue of frame samples.
module tb_therm_adc_sampler;

    localparam int CLK_DIV       = 4;
    localparam int SAMPLE_PERIOD = 200;
    localparam int LEAD_BITS     = 3;
    localparam int AVG_LOG2      = 2;
    localparam int AVG_N         = 1 << AVG_LOG2;
    localparam logic [15:0] LEAD_MASK = ~(16'hFFFF >> LEAD_BITS);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_en = 1'b0;
    logic       adc_sdo = 1'b0;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [7:0] v_therm;
    logic       v_valid;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Shared model/monitor state, written only by the negedge monitor
    // except where the stimulus process clears the window it knows is dropped.
    logic [7:0] exp_q[$];
    logic [7:0] win_q[$];
    logic [7:0] plan_q[$];
    int         adc_mode = 0;
    int         cyc = 0;
    int         frames_started = 0;
    int         frames_done = 0;
    int         valid_cnt = 0;
    int         last_valid_cyc = 0;
    int         prev_valid_cyc = 0;
    int         sclk_idle_err = 0;
    int         adc_r = 0;
    int         cs_low_cnt = 0;
    bit         in_frame = 0;
    bit         sclk_prev = 0;
    bit         valid_prev = 0;
    logic [15:0] word = '0;
    logic [7:0]  cur_sample = '0;

    therm_adc_sampler #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .LEAD_BITS     (LEAD_BITS),
        .AVG_LOG2      (AVG_LOG2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_en (start_en),
        .adc_sdo  (adc_sdo),
        .adc_cs_n (adc_cs_n),
        .adc_sclk (adc_sclk),
        .v_therm  (v_therm),
        .v_valid  (v_valid),
        .busy     (busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model, frame monitor and scoreboard, all sampled on the falling edge.
    always @(negedge clk) begin
        int sum;
        logic [7:0] s;
        cyc++;
        if (adc_cs_n) begin
            if (in_frame) begin
                in_frame = 0;
                if (rst_n) begin
                    check("cs_low_len", cs_low_cnt, 33 * CLK_DIV);
                    check("sclk_edges", adc_r, 16);
                    frames_done++;
                    win_q.push_back(cur_sample);
                    if (win_q.size() == AVG_N) begin
                        sum = 0;
                        foreach (win_q[i]) sum += int'(win_q[i]);
                        exp_q.push_back(8'(sum / AVG_N));
                        win_q.delete();
                    end
                end
            end
            if (adc_sclk) sclk_idle_err++;
            adc_r = 0;
            sclk_prev = 0;
        end else begin
            if (!in_frame) begin
                in_frame = 1;
                frames_started++;
                cs_low_cnt = 0;
                if (plan_q.size() > 0) s = plan_q.pop_front();
                else if (adc_mode == 0) s = 8'h80;
                else s = 8'($urandom_range(0, 255));
                word = 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 1) == 1) word = word | LEAD_MASK;
                word[15-LEAD_BITS -: 8] = s;
                cur_sample = s;
            end
            cs_low_cnt++;
            if (adc_sclk && !sclk_prev) adc_r++;
            sclk_prev = adc_sclk;
            if (!adc_sclk && adc_r < 16) adc_sdo = word[15-adc_r];
        end
        if (v_valid) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
            else check("v_therm", v_therm, exp_q.pop_front());
            if (valid_prev) check("valid_width", 32'd2, 32'd1);
        end
        valid_prev = v_valid;
    end

    task automatic wait_valid(input int budget);
        int tgt;
        int n;
        tgt = valid_cnt + 1;
        n = 0;
        while (valid_cnt < tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("valid_arrived", valid_cnt >= tgt, 1);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int base;
        int n;

        // Reset, with conversions disabled
        wait_cycles(2);
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 0);
        check("rst_v_therm", v_therm, 0);
        check("rst_v_valid", v_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        wait_cycles(450);
        check("disabled_no_frames", frames_started, 0);
        check("disabled_no_valid", valid_cnt, 0);

        // Constant 0x80 conversions, leading bits often forced to 1
        adc_mode = 0;
        wait_cycles($urandom_range(1, 150));
        start_en = 1'b1;
        wait_valid(2000);
        check("const_80", v_therm, 8'h80);
        wait_valid(2000);
        check("valid_interval", last_valid_cyc - prev_valid_cyc, AVG_N * SAMPLE_PERIOD);

        // Directed averages: truncation and full-scale without wrap
        plan_q = '{8'd10, 8'd20, 8'd30, 8'd41, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        wait_valid(2000);
        check("avg_10_20_30_41", v_therm, 8'h19);
        wait_valid(2000);
        check("avg_ff", v_therm, 8'hFF);

        // Random samples
        adc_mode = 1;
        wait_valid(2000);
        wait_valid(2000);

        // Drop start_en after two frames of a window, then re-enable
        base = frames_done;
        n = 0;
        while (frames_done < base + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_drop", busy, 0);
        start_en = 1'b0;
        win_q.delete();
        base = frames_started;
        wait_cycles(300);
        check("dropped_no_frames", frames_started - base, 0);
        start_en = 1'b1;
        base = frames_done;
        wait_valid(2000);
        check("fresh_window_frames", frames_done - base, AVG_N);

        // Asynchronous reset during bit 9 of a frame
        n = 0;
        while (!(!adc_cs_n && adc_r == 10) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("reached_bit9", adc_r, 10);
        #3;
        rst_n = 1'b0;
        win_q.delete();
        #1;
        check("midrst_cs_n", adc_cs_n, 1);
        check("midrst_sclk", adc_sclk, 0);
        check("midrst_v_therm", v_therm, 0);
        check("midrst_busy", busy, 0);
        wait_cycles(4);
        rst_n = 1'b1;
        base = frames_done;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (adc_cs_n && n < 1000);
        check("first_frame_latency", n, SAMPLE_PERIOD);
        wait_valid(2000);
        check("post_reset_frames", frames_done - base, AVG_N);
        check("post_reset_no_pending", exp_q.size(), 0);

        check("sclk_idle_low", sclk_idle_err, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/therm_adc_sampler.md
# therm_adc_sampler

Front-end stage of the thermistor temperature path. It periodically reads an 8-bit serial ADC over a 3-wire SPI-style link and box-car averages 2^AVG_LOG2 conversions. It presents the result as `v_therm[7:0]` with a one-cycle `v_valid` strobe, directly feeding the voltage-to-temperature converter's `v_therm` input.

## Interface
Parameters:
- `CLK_DIV`, 4: clk cycles per SCLK half-period, and length of the setup and quiet phases; ≥1.
- `SAMPLE_PERIOD`, 50000: clk cycles between conversion starts; must be > 34*CLK_DIV + 2.
- `LEAD_BITS`, 3: leading SDO bits discarded before the data MSB; LEAD_BITS + 8 ≤ 16.
- `AVG_LOG2`, 2: log2 of conversions averaged per output; 0–4.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_en`  in  1  enables periodic conversions.
- `adc_sdo`  in  1  ADC serial data, MSB first.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock, idle low.
- `v_therm`  out  8  averaged thermistor voltage code.
- `v_valid`  out  1  one-cycle strobe; `v_therm` is new.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Period timer: free-running counter, 0 to SAMPLE_PERIOD-1, then wraps. It counts regardless of `start_en`. A tick fires in the wrap cycle.
- FSM states: IDLE, SETUP, SHIFT, QUIET, ACCUM.
  - IDLE → SETUP on tick while `start_en`=1. A tick with `start_en`=0 is ignored. Ticks in any other state are dropped.
  - SETUP: `adc_cs_n`=0, `adc_sclk`=0 for CLK_DIV cycles → SHIFT.
  - SHIFT: 16 SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high. On the cycle SCLK goes high, capture the registered value of `adc_sdo`. Bit k (0-based) is kept iff LEAD_BITS ≤ k < LEAD_BITS+8; the first kept bit is the MSB. After the 16th high phase, SCLK returns low → QUIET.
  - QUIET: `adc_cs_n`=1 for CLK_DIV cycles → ACCUM.
  - ACCUM (1 cycle): acc += sample and cnt += 1. If cnt was 2^AVG_LOG2-1:
    - `v_therm` ← (acc + sample) >> AVG_LOG2, truncated.
    - `v_valid`=1 on the next cycle.
    - acc and cnt cleared.
    - Then → IDLE.
- Accumulator width is 8+AVG_LOG2 bits, so no overflow is possible; 0xFF×16 fits in 12 bits.
- `start_en` falling mid-frame: the frame completes and is accumulated. While in IDLE with `start_en`=0, acc and cnt are held at 0, so the averaging window restarts cleanly on re-enable.
- `v_therm` holds its last value between strobes.

## Timing
- Reset values (async assert): `adc_cs_n`=1, `adc_sclk`=0, `v_therm`=0x00, `v_valid`=0, `busy`=0; FSM=IDLE, timer=0, acc=0, cnt=0.
- Reset asserted mid-frame: `adc_cs_n` goes high and SCLK low immediately. The partial sample is discarded and no `v_valid` is issued.
- First tick occurs SAMPLE_PERIOD cycles after reset release.
- `adc_cs_n` is low for exactly 33*CLK_DIV cycles (setup + 32 half-periods). A frame lasts 34*CLK_DIV cycles from CS fall to ACCUM, plus 1 ACCUM cycle.
- `v_valid` latency: the cycle after ACCUM of the 2^AVG_LOG2-th frame. It is a one-cycle pulse with no handshake; the consumer must take it.
- `busy` rises the cycle after the tick and falls the cycle after ACCUM.

## Structure
- `therm_pkg`:
  - FSM state enum.
  - `THERM_FRAME_BITS` = 16.
  - `THERM_CODE_W` = 8.
- Sub-module `therm_spi_rx`: SCLK divider, 16-bit frame shifter and bit selection. Interface: start pulse, `done` pulse and 8-bit `sample`.
- The parent holds the period timer, FSM sequencing and the accumulator.

## Test plan
Unless stated, CLK_DIV=4, SAMPLE_PERIOD=200, LEAD_BITS=3, AVG_LOG2=2.
- ADC model returns 0x80 every frame → first `v_valid` after the 4th frame with `v_therm`=0x80, then every 800 cycles.
- Samples 10, 20, 30, 41 → `v_therm`=0x19 (101>>2 = 25).
- Four samples of 0xFF → `v_therm`=0xFF, with no wrap.
- Per frame, exactly 16 SCLK rising edges, `adc_cs_n` low for 132 cycles, and SCLK idle low outside frames. Leading SDO bits set to 1 do not affect the code.
- `start_en`=0 from reset → `adc_cs_n` stays high and no `v_valid`. After 2 frames, drop and re-raise `start_en` → the next `v_valid` comes after 4 fresh frames.
- Assert `rst_n` during bit 9 of SHIFT → `adc_cs_n`=1 and `v_therm`=0x00 asynchronously, no `v_valid`. Normal frames resume SAMPLE_PERIOD cycles after release.
